imem_boot_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the single-cycle CPU's instruction memory. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and writes them sequentially into instruction memory from address 0. Holds the CPU in reset until the image is fully written, then releases it.

---
 rtl/imem_boot_loader.sv | 210 +++++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a length-prefixed byte image into instruction memory.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int DEPTH_WORDS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        im_we_o,
  output logic [31:0] im_addr_o,
  output logic [31:0] im_data_o,
  output logic        cpu_rst_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] words_o
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_FLUSH,
    S_DONE,
    S_ERROR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_FLUSH,
    S_DONE,
    S_ERROR
  } state_t;
`endif

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_ready;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_cpu_rst;
  logic        r_done;
  logic        r_err;
  logic [15:0] r_words;
  logic [15:0] r_len;
  logic [7:0]  r_len_lo;
  logic [1:0]  r_bcnt;
  logic [31:0] r_asm;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  logic        w_acc;
  logic        w_start;
  logic        w_wr;
  logic        w_last_word;
  logic [15:0] w_len;
  logic [31:0] w_word;
  logic        w_ready_nxt;

  // Next-state logic plus the byte-lane merge for the word being assembled.
  always_comb begin
    w_state_nxt = r_state;
    w_acc       = r_ready & byte_valid_i;
    w_start     = start_i & ((r_state == S_IDLE) |
                             (r_state == S_DONE) |
                             (r_state == S_ERROR));
    w_len       = {byte_i, r_len_lo};
    w_word      = r_asm;
    w_word[{r_bcnt, 3'b000} +: 8] = byte_i;
    w_wr        = (r_state == S_DATA) & w_acc & (r_bcnt == 2'd3);
    w_last_word = (r_words + 16'd1) == r_len;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (w_acc) w_state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (w_acc) begin
          if (w_len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            w_state_nxt = S_CHECK;
`else
            w_state_nxt = S_FLUSH;
`endif
          end else if (w_len > 16'(DEPTH_WORDS)) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_wr && w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
          w_state_nxt = S_CHECK;
`else
          w_state_nxt = S_FLUSH;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (w_acc) begin
          w_state_nxt = (byte_i == r_csum) ? S_FLUSH : S_ERROR;
        end
      end
`endif
      S_FLUSH: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (w_start) w_state_nxt = S_LEN_LO;
      end
      S_ERROR: begin
        if (w_start) w_state_nxt = S_LEN_LO;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_ready_nxt = (w_state_nxt == S_LEN_LO) |
                  (w_state_nxt == S_LEN_HI) |
`ifdef LOADER_CHECKSUM_EN
                  (w_state_nxt == S_CHECK) |
`endif
                  (w_state_nxt == S_DATA);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Registered outputs, length capture, word assembly and write issue.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ready   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= 32'd0;
      r_data    <= 32'd0;
      r_cpu_rst <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_words   <= 16'd0;
      r_len     <= 16'd0;
      r_len_lo  <= 8'd0;
      r_bcnt    <= 2'd0;
      r_asm     <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      r_csum    <= 8'd0;
`endif
    end else begin
      r_ready   <= w_ready_nxt;
      r_we      <= w_wr;
      r_cpu_rst <= (w_state_nxt == S_DONE);
      r_done    <= (w_state_nxt == S_DONE);
      r_err     <= (w_state_nxt == S_ERROR);
      if (w_start) begin
        r_words <= 16'd0;
        r_bcnt  <= 2'd0;
        r_asm   <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
        r_csum  <= 8'd0;
`endif
      end
      if ((r_state == S_LEN_LO) && w_acc) begin
        r_len_lo <= byte_i;
      end
      if ((r_state == S_LEN_HI) && w_acc) begin
        r_len <= w_len;
      end
      if ((r_state == S_DATA) && w_acc) begin
        r_asm  <= w_word;
        r_bcnt <= r_bcnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        r_csum <= r_csum ^ byte_i;
`endif
      end
      if (w_wr) begin
        r_addr  <= {14'd0, r_words, 2'b00};
        r_data  <= w_word;
        r_words <= r_words + 16'd1;
      end
    end
  end

  assign byte_ready_o = r_ready;
  assign im_we_o      = r_we;
  assign im_addr_o    = r_addr;
  assign im_data_o    = r_data;
  assign cpu_rst_o    = r_cpu_rst;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign words_o      = r_words;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: scoreboard bench for the instruction-memory loader.
// Expected writes are queued by stimulus and popped by a write monitor.
module tb_imem_boot_loader;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  byte_i = 8'd0;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic        im_we_o;
  logic [31:0] im_addr_o;
  logic [31:0] im_data_o;
  logic        cpu_rst_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] words_o;

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  stream[$];

  imem_boot_loader #(.DEPTH_WORDS(32)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .start_i(start_i),
    .byte_i(byte_i),
    .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o),
    .im_we_o(im_we_o),
    .im_addr_o(im_addr_o),
    .im_data_o(im_data_o),
    .cpu_rst_o(cpu_rst_o),
    .done_o(done_o),
    .err_o(err_o),
    .words_o(words_o)
  );

  always #5 clk_i = ~clk_i;

  // Write monitor: every strobe must match the head of the expected queue.
  always @(negedge clk_i) begin
    if (rst_i && im_we_o) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%h data=%h",
                 im_addr_o, im_data_o);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({im_addr_o, im_data_o} !== e) begin
          bad++;
          $display("FAIL write got=%h_%h want=%h_%h",
                   im_addr_o, im_data_o, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk_i);
    byte_i = b;
    byte_valid_i = 1'b1;
    n = 0;
    while (!byte_ready_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    if (!byte_ready_o) begin
      total++;
      bad++;
      $display("FAIL send_timeout byte=%h got=ready0 want=ready1", b);
    end else begin
      @(posedge clk_i);
    end
  endtask

  task automatic send_seq(input bit gaps);
    foreach (stream[i]) begin
      if (gaps && i > 0) begin
        @(negedge clk_i);
        byte_valid_i = 1'b0;
      end
      send(stream[i]);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic finish_check(input string name, input logic [15:0] w);
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    chk({name, "_done_k1"}, {62'd0, done_o, cpu_rst_o}, 64'd0);
    @(negedge clk_i);
    chk({name, "_done_k2"}, {62'd0, done_o, cpu_rst_o}, 64'd3);
    chk({name, "_words"}, {48'd0, words_o}, {48'd0, w});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    chk("reset_outputs",
        {byte_ready_o, im_we_o, cpu_rst_o, done_o, err_o, 1'b0,
         words_o[9:0], im_addr_o[23:0], im_data_o[23:0]}, 64'd0);
    chk("reset_addr_data_hi",
        {im_addr_o[31:24], im_data_o[31:24], words_o[15:10]}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("idle_ready", {63'd0, byte_ready_o}, 64'd0);

    // Two-word load, back-to-back
    pulse_start();
    chk("start_ready", {63'd0, byte_ready_o}, 64'd1);
    exp_q.push_back({32'h0, 32'h00500513});
    exp_q.push_back({32'h4, 32'h00A00593});
    stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50,
               8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    stream.push_back(8'h70);
`endif
    send_seq(1'b0);
    finish_check("b2b", 16'd2);

    // Same image with gaps between bytes
    pulse_start();
    exp_q.push_back({32'h0, 32'h00500513});
    exp_q.push_back({32'h4, 32'h00A00593});
    send_seq(1'b1);
    finish_check("gaps", 16'd2);

    // Bytes offered in DONE are not consumed
    @(negedge clk_i);
    byte_i = 8'hEE;
    byte_valid_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("done_hold",
        {45'd0, byte_ready_o, done_o, cpu_rst_o, words_o},
        {45'd0, 1'b0, 1'b1, 1'b1, 16'd2});
    byte_valid_i = 1'b0;

    // Oversize image
    pulse_start();
    stream = '{8'h21, 8'h00};
    send_seq(1'b0);
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    chk("oversize_err",
        {60'd0, err_o, cpu_rst_o, done_o, byte_ready_o}, 64'h8);
    @(negedge clk_i);
    chk("oversize_hold", {62'd0, err_o, cpu_rst_o}, 64'h2);
    pulse_start();
    chk("recover", {62'd0, byte_ready_o, err_o}, 64'h2);

    // Zero-length image
    stream = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    stream.push_back(8'h00);
`endif
    send_seq(1'b0);
    finish_check("zero", 16'd0);

    // One-word load with start pulsed during DATA
    pulse_start();
    exp_q.push_back({32'h0, 32'hDDCCBBAA});
    stream = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    send_seq(1'b0);
    pulse_start();
    chk("ign_start", {47'd0, byte_ready_o, words_o}, {47'd0, 1'b1, 16'd0});
    stream = '{8'hCC, 8'hDD};
`ifdef LOADER_CHECKSUM_EN
    stream.push_back(8'h00);
`endif
    send_seq(1'b0);
    finish_check("one", 16'd1);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match then mismatch
    pulse_start();
    exp_q.push_back({32'h0, 32'h44332211});
    stream = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_seq(1'b0);
    finish_check("cs_ok", 16'd1);
    pulse_start();
    exp_q.push_back({32'h0, 32'h44332211});
    stream = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    send_seq(1'b0);
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    chk("cs_bad", {61'd0, err_o, cpu_rst_o, done_o}, 64'h4);
`endif

    // Reset in the middle of DATA, while a write strobe is pending
    pulse_start();
    stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00};
    send_seq(1'b0);
    #1;
    rst_i = 1'b0;
    #1;
    chk("midreset_ctl",
        {57'd0, byte_ready_o, im_we_o, cpu_rst_o, done_o, err_o, 2'b00},
        64'd0);
    chk("midreset_dat", {im_addr_o, im_data_o}, 64'd0);
    chk("midreset_words", {48'd0, words_o}, 64'd0);
    byte_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("post_reset_idle", {62'd0, byte_ready_o, done_o}, 64'd0);

    repeat (2) @(negedge clk_i);
    chk("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
